// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int LOADER_LEN_BYTES  = 4;
  localparam int LOADER_WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes into a little-endian 32-bit word; pulses word_valid the cycle after the last byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic [31:0] word_nxt,
  output logic        byte_last,
  output logic        word_valid
);

  localparam int CW = $clog2(LOADER_WORD_BYTES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;
  logic          valid_q, valid_d;

  // Newest byte lands in the top lane, so the first byte ends up in [7:0].
  assign word_nxt   = {in_data, word_q[31:8]};
  assign byte_last  = (cnt_q == CW'(LOADER_WORD_BYTES - 1));
  assign word       = word_q;
  assign word_valid = valid_q;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (in_valid) begin
      word_d  = word_nxt;
      cnt_d   = cnt_q + CW'(1);
      valid_d = byte_last;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives LEN/DATA/CHECK byte stream, writes instruction memory, verifies XOR.
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int          WCW   = ADDR_WIDTH + 1;

  loader_state_t  state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [WCW-1:0] len_q, len_d;
  logic [7:0]     xor_q, xor_d;
  logic           data_wr_q, data_wr_d;

  logic        accept;
  logic        pk_in_valid;
  logic [31:0] pk_word;
  logic [31:0] pk_word_nxt;
  logic        pk_byte_last;
  logic        pk_word_valid;

  assign busy        = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);
  assign rx_ready    = busy && !start;
  assign accept      = rx_valid && rx_ready;
  assign pk_in_valid = accept && ((state_q == LEN) || (state_q == DATA));

  assign done      = (state_q == DONE);
  assign err       = (state_q == ERROR);
  assign mem_we    = pk_word_valid && data_wr_q;
  assign mem_wdata = pk_word;
  // Counter advances on the write cycle itself, so it still holds this word's index.
  assign mem_addr  = word_cnt_q[ADDR_WIDTH-1:0];

  byte_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (start),
    .in_valid   (pk_in_valid),
    .in_data    (rx_data),
    .word       (pk_word),
    .word_nxt   (pk_word_nxt),
    .byte_last  (pk_byte_last),
    .word_valid (pk_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    xor_d      = xor_q;
    data_wr_d  = 1'b0;

    if (mem_we) word_cnt_d = word_cnt_q + WCW'(1);

    if (start) begin
      state_d    = LEN;
      word_cnt_d = '0;
      len_d      = '0;
      xor_d      = '0;
    end else if (accept) begin
      unique case (state_q)
        LEN: begin
          if (pk_byte_last) begin
            if (pk_word_nxt == 32'd0) begin
              state_d = CHECK;
            end else if (pk_word_nxt > DEPTH) begin
              state_d = ERROR;
            end else begin
              state_d = DATA;
              len_d   = pk_word_nxt[WCW-1:0];
            end
          end
        end
        DATA: begin
          xor_d = xor_q ^ rx_data;
          if (pk_byte_last) begin
            data_wr_d = 1'b1;
            if (word_cnt_q + WCW'(1) == len_q) state_d = CHECK;
          end
        end
        CHECK: state_d = (rx_data == xor_q) ? DONE : ERROR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      xor_q      <= '0;
      data_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      data_wr_q  <= data_wr_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a stream-level reference model and a per-cycle write checker.
module tb_instr_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stream-level model: queues expected writes, returns 0 incomplete, 1 done, 2 err.
  function automatic int model(input byte unsigned s[$]);
    int unsigned n;
    logic [7:0]  x;
    logic [31:0] w;
    int          b;
    if (s.size() < 4) return 0;
    n = {s[3], s[2], s[1], s[0]};
    if (n > (1 << AW)) return 2;
    x = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      b = 4 + 4 * i;
      if (s.size() < b + 4) return 0;
      w = {s[b+3], s[b+2], s[b+1], s[b]};
      x = x ^ s[b] ^ s[b+1] ^ s[b+2] ^ s[b+3];
      exp_q.push_back('{addr: i[AW-1:0], data: w});
    end
    if (s.size() < 4 + 4 * int'(n) + 1) return 0;
    return (s[4 + 4 * n] == x) ? 1 : 2;
  endfunction

  function automatic void build(input logic [31:0] w[$], input logic [7:0] corrupt,
                                output byte unsigned s[$]);
    logic [7:0]  x;
    logic [31:0] n;
    logic [31:0] cur;
    s = {};
    x = 8'h00;
    n = w.size();
    for (int i = 0; i < 4; i++) s.push_back(n[8*i +: 8]);
    for (int i = 0; i < w.size(); i++) begin
      cur = w[i];
      for (int k = 0; k < 4; k++) begin
        s.push_back(cur[8*k +: 8]);
        x = x ^ cur[8*k +: 8];
      end
    end
    s.push_back(x ^ corrupt);
  endfunction

  // Per-cycle checker: every write must be the next expected one.
  always @(negedge clk) begin
    if (rstn) begin
      chk("ready_implies_busy", {31'd0, rx_ready & ~busy}, 32'd0);
      chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=addr %0d data %h required=no write", mem_addr, mem_wdata);
        end else begin
          chk("write_addr", 32'(mem_addr), 32'(exp_q[0].addr));
          chk("write_data", mem_wdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic pulse_start(input bit with_byte);
    start    = 1'b1;
    rx_valid = with_byte;
    rx_data  = 8'hAA;
    #1;
    chk("ready_low_on_start", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic send(input byte unsigned s[$], input bit gaps);
    int unsigned n;
    bit          acc;
    int          guard;
    n = (s.size() >= 4) ? {s[3], s[2], s[1], s[0]} : 0;
    for (int i = 0; i < s.size(); i++) begin
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        rx_data  = s[i];
        rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        acc = rx_valid && rx_ready;
        @(posedge clk);
        @(negedge clk);
        guard++;
        if (!acc && guard > 100) begin
          checks++;
          failures++;
          $display("FAIL byte_timeout actual=byte %0d not accepted required=accepted", i);
          rx_valid = 1'b0;
          return;
        end
      end
      if (i >= 4 && n <= (1 << AW) && i < 4 + 4 * int'(n) && ((i - 4) % 4) == 3) begin
        chk("we_timing", {31'd0, mem_we}, 32'd1);
        chk("we_timing_addr", 32'(mem_addr), 32'((i - 4) / 4));
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input byte unsigned s[$], input bit gaps, input int lit, input bit do_start);
    int outcome;
    outcome = model(s);
    chk("model_outcome", outcome, lit);
    if (do_start) pulse_start(1'b0);
    send(s, gaps);
    chk("done_after_check", {31'd0, done}, (outcome == 1) ? 32'd1 : 32'd0);
    chk("err_after_check", {31'd0, err}, (outcome == 2) ? 32'd1 : 32'd0);
    chk("ready_after_end", {31'd0, rx_ready}, 32'd0);
    chk("busy_after_end", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("writes_outstanding", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  byte unsigned s2w[$];
  byte unsigned sbad[$];
  byte unsigned s[$];
  logic [31:0]  words[$];
  int           r;

  initial begin
    s2w  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'hC0, 8'h08,
             8'h13, 8'h01, 8'h01, 8'hFE, 8'hCA};
    sbad = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h00, 8'hC0, 8'h08,
             8'h13, 8'h01, 8'h01, 8'hFE, 8'hCB};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_flags", {28'd0, rx_ready, busy, done, err}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, rx_ready}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Model pins
    r = model(s2w);
    chk("pin_model_w0", exp_q[0].data, 32'h08C000EF);
    chk("pin_model_w1", exp_q[1].data, 32'hFE010113);
    exp_q.delete();

    run_load(s2w, 1'b0, 1, 1'b1);
    run_load(sbad, 1'b0, 2, 1'b1);
    run_load(s2w, 1'b1, 1, 1'b1);

    // Overflow
    s = '{8'h41, 8'h00, 8'h00, 8'h00};
    run_load(s, 1'b0, 2, 1'b1);

    // Empty image
    s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(s, 1'b0, 1, 1'b1);

    // Full depth
    words = {};
    for (int i = 0; i < 64; i++) words.push_back($urandom());
    build(words, 8'h00, s);
    r = model(s);
    chk("pin_full_count", exp_q.size(), 32'd64);
    chk("pin_full_last_addr", 32'(exp_q[63].addr), 32'd63);
    exp_q.delete();
    run_load(s, 1'b0, 1, 1'b1);

    // Restart mid-DATA, with a byte presented on the start cycle
    pulse_start(1'b0);
    s = s2w[0:9];
    r = model(s);
    chk("pin_partial_outcome", r, 0);
    send(s, 1'b0);
    repeat (2) @(negedge clk);
    chk("partial_writes_done", exp_q.size(), 32'd0);
    pulse_start(1'b1);
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_load(s, 1'b0, 1, 1'b0);

    // Reset while a write is pending
    pulse_start(1'b0);
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    send(s, 1'b0);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("we_before_reset", {31'd0, mem_we}, 32'd1);
    chk("wdata_before_reset", mem_wdata, 32'h44332211);
    rstn = 1'b0;
    #1;
    chk("async_rst_we", {31'd0, mem_we}, 32'd0);
    chk("async_rst_wdata", mem_wdata, 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_flags", {28'd0, rx_ready, busy, done, err}, 32'd0);
    rx_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Recovery after reset
    s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(s, 1'b0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that writes instruction memory, the write-side counterpart to the fetch stage's read port. Accepts a byte stream from the serial receiver over a valid/ready handshake, assembles little-endian 32-bit instruction words, writes them to consecutive word addresses, verifies an XOR checksum, and only then asserts `done`. `done` drives the fetch stage's `enabled` input, so the core does not fetch until a verified image is in memory.

## Interface
- `ADDR_WIDTH`, default 6: word-address width; memory depth is 2^ADDR_WIDTH (64 words).
- `clk`  in  1  system clock; single clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load, or restarts one.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_WIDTH  word address for the write.
- `mem_wdata`  out  32  instruction word.
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  verified image loaded; feeds the fetch stage's `enabled`.
- `err`  out  1  load failed: length overflow or checksum mismatch.

## Operation
- Stream format:
  - LEN: 4 bytes, word count N, little-endian.
  - DATA: N words, 4 bytes each, little-endian (first byte goes to [7:0]).
  - CHECK: 1 byte, the XOR of all DATA bytes. LEN bytes are excluded.
- A byte is accepted on a cycle where `rx_valid && rx_ready`.
- States and transitions:
  - IDLE → LEN on `start`.
  - LEN → DATA after the 4th byte when 0 < N ≤ 2^ADDR_WIDTH.
  - LEN → CHECK after the 4th byte when N == 0.
  - LEN → ERROR after the 4th byte when N > 2^ADDR_WIDTH.
  - DATA → CHECK after the 4th byte of word N−1.
  - CHECK → DONE when the received byte equals the running XOR.
  - CHECK → ERROR when it does not.
- DONE and ERROR hold until `start` or reset.
- `start` in any state, including mid-load, aborts the load. All of the following happen together:
  - state → LEN;
  - byte counter, word counter and running XOR cleared;
  - `done` and `err` cleared.
- `rx_ready` = 1 in LEN, DATA and CHECK; 0 in IDLE, DONE and ERROR. `rx_ready` is also 0 in the cycle `start` is sampled, so no byte is accepted on that cycle.
- `busy` = 1 in LEN, DATA and CHECK.
- Counters:
  - byte-in-word counter: 2 bits, wraps 3 → 0;
  - word counter: ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH is representable;
  - `mem_addr` = word counter [ADDR_WIDTH−1:0].
- Running XOR (8 bits) updates on every accepted DATA byte.
- On an ERROR from checksum mismatch, words already written stay in memory. `done` stays 0, so the core remains disabled.

## Timing
- Reset values: state IDLE; `rx_ready`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr` = 0; `mem_wdata` = 0; counters and XOR = 0.
- Write latency: the 4th byte of a word is accepted at edge k. `mem_we` = 1 for the single cycle after edge k, with `mem_addr` and `mem_wdata` registered and stable in that cycle.
- `mem_we` is never asserted for two consecutive cycles with the same address.
- The loader sustains 1 byte/cycle. `rx_valid` gaps stall the loader without losing state.
- `done` or `err` rises the cycle after the CHECK byte is accepted. `err` on overflow rises the cycle after the 4th LEN byte.
- Reset mid-load: outputs go to their reset values immediately (asynchronously). Any pending `mem_we` is suppressed.
- `start` coincident with an accepted byte: `start` wins and the byte is dropped.

## Structure
- Shared package `loader_pkg`:
  - `loader_state_t` enum: IDLE, LEN, DATA, CHECK, DONE, ERROR;
  - `LOADER_LEN_BYTES = 4`;
  - `LOADER_WORD_BYTES = 4`.
- One sub-module, `byte_packer`, with the same clock and reset:
  - shifts 4 bytes into a 32-bit little-endian word;
  - outputs `word_valid` for one cycle on completion;
  - is used for both the LEN and DATA fields.
- The top-level FSM owns the counters, the XOR, the write strobe and the status flags.

## Test plan
- Two-word load. Stream 02 00 00 00, EF 00 C0 08, 13 01 01 FE, CA → `mem_we` at addr 0 with 0x08C000EF, then addr 1 with 0xFE010113; `done` = 1 one cycle after CA; `err` = 0.
- Same stream with last byte CB → both writes occur; `err` = 1; `done` = 0; `rx_ready` = 0.
- Overflow. Length 41 00 00 00 (65) with ADDR_WIDTH = 6 → `err` = 1 after the 4th byte; no `mem_we` ever.
- Full depth. Length 40 00 00 00 (64) with 64 words → last write at addr 63; no wrap to addr 0; `done` = 1 after a correct checksum.
- Empty image. Length 0 with checksum 00 → `done` = 1; no writes.
- Backpressure and restart:
  - random `rx_valid` gaps → same writes as the gap-free run;
  - `start` pulsed mid-DATA → the next word writes to addr 0;
  - `rstn` low mid-word → all outputs are 0 immediately.
